// File: rtl/fpu_result_register_if.sv
// Host/core-facing signal bundle of the FPU result register.
// The master side is the host plus FPU core; the slave side is the register block.
interface fpu_result_register_if;
   logic        fpu_rst_w;
   logic        fpu_doorbell_w;
   logic        simd_doorbell;
   logic        fpu_result_valid;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_flags;
   logic        host_read_ack;
   logic        flags_clear;
   logic        irq_enable;
   logic [31:0] result_out;
   logic [4:0]  flags_last;
   logic [4:0]  flags_sticky;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic        irq;
   logic [1:0]  state_dbg;

   // Doorbells and fpu_result_valid are single-cycle pulses sampled on the
   // rising clock edge; there is no back-pressure. busy/done show acceptance.
   modport master (
      output fpu_rst_w, fpu_doorbell_w, simd_doorbell, fpu_result_valid,
             fpu_result, fpu_flags, host_read_ack, flags_clear, irq_enable,
      input  result_out, flags_last, flags_sticky, busy, done, timeout_err,
             irq, state_dbg
   );

   modport slave (
      input  fpu_rst_w, fpu_doorbell_w, simd_doorbell, fpu_result_valid,
             fpu_result, fpu_flags, host_read_ack, flags_clear, irq_enable,
      output result_out, flags_last, flags_sticky, busy, done, timeout_err,
             irq, state_dbg
   );
endinterface

// File: rtl/fpu_result_register.sv
// Tracks one outstanding FPU/SIMD operation, captures its result and flags,
// and holds them with busy/done/timeout status and a maskable interrupt.
module fpu_result_register #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fpu_result_register_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       result_q, result_d;
   logic [4:0]        flags_last_q, flags_last_d;
   logic [4:0]        sticky_q, sticky_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;
   logic              start;
   logic              soft_rst;

   assign start    = bus.fpu_doorbell_w | bus.simd_doorbell;
   assign soft_rst = bus.fpu_rst_w & bus.fpu_doorbell_w;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         result_q     <= '0;
         flags_last_q <= '0;
         sticky_q     <= '0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         result_q     <= result_d;
         flags_last_q <= flags_last_d;
         sticky_q     <= sticky_d;
         timeout_q    <= timeout_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         irq_q        <= irq_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      flags_last_d = flags_last_q;
      // Clear is applied before any capture OR so a coincident capture wins.
      sticky_d     = bus.flags_clear ? 5'b0 : sticky_q;
      timeout_d    = timeout_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = BUSY;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.fpu_result_valid) begin
               state_d      = DONE;
               result_d     = bus.fpu_result;
               flags_last_d = bus.fpu_flags;
               sticky_d     = sticky_d | bus.fpu_flags;
               timeout_d    = 1'b0;
            end else if (cnt_q == TERM_CNT) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               state_d   = BUSY;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end else if (bus.host_read_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (soft_rst) begin
         state_d      = IDLE;
         cnt_d        = '0;
         result_d     = '0;
         flags_last_d = '0;
         sticky_d     = '0;
         timeout_d    = 1'b0;
      end

      busy_d = (state_d == BUSY);
      done_d = (state_d == DONE);
      irq_d  = done_d & bus.irq_enable;
   end

   assign bus.result_out   = result_q;
   assign bus.flags_last   = flags_last_q;
   assign bus.flags_sticky = sticky_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.timeout_err  = timeout_q;
   assign bus.irq          = irq_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_fpu_result_register.sv
// Directed bench for fpu_result_register: a cycle model checked every negedge
// plus literal expectations at the interesting points of each scenario.
module tb_fpu_result_register;
   localparam int TIMEOUT = 64;

   logic clk;
   logic reset_n;
   int   n_total = 0;
   int   n_pass  = 0;

   fpu_result_register_if bus ();

   fpu_result_register #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 busy, 2 done; age counts edges spent busy.
   int          ph;
   int          age;
   logic [31:0] m_res;
   logic [4:0]  m_fl;
   logic [4:0]  m_st;
   logic        m_to;
   logic        m_irq;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         ph = 0; age = 0; m_res = '0; m_fl = '0; m_st = '0; m_to = 0; m_irq = 0;
      end else if (bus.fpu_rst_w && bus.fpu_doorbell_w) begin
         ph = 0; age = 0; m_res = '0; m_fl = '0; m_st = '0; m_to = 0; m_irq = 0;
      end else begin
         if (bus.flags_clear) m_st = '0;
         if (ph == 0) begin
            if (bus.fpu_doorbell_w || bus.simd_doorbell) begin
               ph = 1; age = 0; m_to = 0;
            end
         end else if (ph == 1) begin
            age++;
            if (bus.fpu_result_valid) begin
               m_res = bus.fpu_result; m_fl = bus.fpu_flags;
               m_st = m_st | bus.fpu_flags; ph = 2; m_to = 0;
            end else if (age == TIMEOUT) begin
               ph = 2; m_to = 1;
            end
         end else begin
            if (bus.fpu_doorbell_w || bus.simd_doorbell) begin
               ph = 1; age = 0; m_to = 0;
            end else if (bus.host_read_ack) begin
               ph = 0;
            end
         end
         m_irq = (ph == 2) && bus.irq_enable;
      end
   end

   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         chk("m_busy",   bus.busy,         (ph == 1));
         chk("m_done",   bus.done,         (ph == 2));
         chk("m_result", bus.result_out,   m_res);
         chk("m_flast",  bus.flags_last,   m_fl);
         chk("m_sticky", bus.flags_sticky, m_st);
         chk("m_tmo",    bus.timeout_err,  m_to);
         chk("m_irq",    bus.irq,          m_irq);
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},   bus.busy,         0);
      chk({tag, "_done"},   bus.done,         0);
      chk({tag, "_result"}, bus.result_out,   0);
      chk({tag, "_flast"},  bus.flags_last,   0);
      chk({tag, "_sticky"}, bus.flags_sticky, 0);
      chk({tag, "_tmo"},    bus.timeout_err,  0);
      chk({tag, "_irq"},    bus.irq,          0);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.fpu_rst_w = 0; bus.fpu_doorbell_w = 0; bus.simd_doorbell = 0;
      bus.fpu_result_valid = 0; bus.fpu_result = '0; bus.fpu_flags = '0;
      bus.host_read_ack = 0; bus.flags_clear = 0; bus.irq_enable = 1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      cyc();

      // Basic operation, result two cycles after doorbell.
      bus.fpu_doorbell_w = 1; cyc(); bus.fpu_doorbell_w = 0;
      chk("t1_busy_a", bus.busy, 1);
      cyc();
      chk("t1_busy_b", bus.busy, 1);
      bus.fpu_result_valid = 1; bus.fpu_result = 32'h3F80_0000; bus.fpu_flags = 5'b00001;
      cyc(); bus.fpu_result_valid = 0;
      chk("t1_done",   bus.done, 1);
      chk("t1_busy_c", bus.busy, 0);
      chk("t1_result", bus.result_out, 32'h3F80_0000);
      chk("t1_flast",  bus.flags_last, 5'b00001);
      chk("t1_sticky", bus.flags_sticky, 5'b00001);
      chk("t1_irq",    bus.irq, 1);

      // Second operation accumulates sticky flags, then ack.
      bus.simd_doorbell = 1; cyc(); bus.simd_doorbell = 0;
      chk("t2_busy", bus.busy, 1);
      chk("t2_irq",  bus.irq, 0);
      bus.fpu_result_valid = 1; bus.fpu_result = 32'h4000_0000; bus.fpu_flags = 5'b10000;
      cyc(); bus.fpu_result_valid = 0;
      chk("t2_sticky", bus.flags_sticky, 5'b10001);
      chk("t2_flast",  bus.flags_last, 5'b10000);
      bus.host_read_ack = 1; cyc(); bus.host_read_ack = 0;
      chk("t2_ack_done", bus.done, 0);
      chk("t2_ack_irq",  bus.irq, 0);
      chk("t2_ack_busy", bus.busy, 0);

      // Timeout after exactly TIMEOUT cycles busy; late result discarded.
      bus.fpu_doorbell_w = 1; cyc(); bus.fpu_doorbell_w = 0;
      for (int i = 1; i < TIMEOUT; i++) cyc();
      chk("t3_pre_done", bus.done, 0);
      chk("t3_pre_busy", bus.busy, 1);
      cyc();
      chk("t3_done",   bus.done, 1);
      chk("t3_tmo",    bus.timeout_err, 1);
      chk("t3_result", bus.result_out, 32'h4000_0000);
      bus.fpu_result_valid = 1; bus.fpu_result = 32'hDEAD_BEEF; bus.fpu_flags = 5'b01000;
      cyc(); bus.fpu_result_valid = 0;
      chk("t3_late_result", bus.result_out, 32'h4000_0000);
      chk("t3_late_sticky", bus.flags_sticky, 5'b10001);

      // Valid on the terminal-count cycle wins over timeout.
      bus.fpu_doorbell_w = 1; cyc(); bus.fpu_doorbell_w = 0;
      chk("t4_tmo_clr", bus.timeout_err, 0);
      for (int i = 1; i < TIMEOUT; i++) cyc();
      bus.fpu_result_valid = 1; bus.fpu_result = 32'h1234_5678; bus.fpu_flags = 5'b00010;
      cyc(); bus.fpu_result_valid = 0;
      chk("t4_done",   bus.done, 1);
      chk("t4_tmo",    bus.timeout_err, 0);
      chk("t4_result", bus.result_out, 32'h1234_5678);
      chk("t4_sticky", bus.flags_sticky, 5'b10011);
      bus.host_read_ack = 1; bus.simd_doorbell = 1; cyc();
      bus.host_read_ack = 0; bus.simd_doorbell = 0;
      chk("t4_restart_busy", bus.busy, 1);
      chk("t4_restart_done", bus.done, 0);

      // Soft reset mid-BUSY, later valid ignored.
      cyc();
      bus.fpu_rst_w = 1; bus.fpu_doorbell_w = 1; cyc();
      bus.fpu_rst_w = 0; bus.fpu_doorbell_w = 0;
      chk_all_zero("t5_soft");
      bus.fpu_result_valid = 1; bus.fpu_result = 32'hCAFE_F00D; bus.fpu_flags = 5'b11111;
      cyc(); bus.fpu_result_valid = 0;
      chk("t5_ign_done",   bus.done, 0);
      chk("t5_ign_result", bus.result_out, 0);

      // Masked interrupt, then unmask in DONE; clear coincident with capture.
      bus.irq_enable = 0;
      bus.fpu_doorbell_w = 1; cyc(); bus.fpu_doorbell_w = 0;
      bus.fpu_result_valid = 1; bus.fpu_result = 32'hC049_0FDB; bus.fpu_flags = 5'b01000;
      cyc(); bus.fpu_result_valid = 0;
      chk("t6_done",   bus.done, 1);
      chk("t6_irq0",   bus.irq, 0);
      chk("t6_sticky", bus.flags_sticky, 5'b01000);
      bus.irq_enable = 1; cyc();
      chk("t6_irq1", bus.irq, 1);
      bus.host_read_ack = 1; cyc(); bus.host_read_ack = 0;
      bus.fpu_doorbell_w = 1; cyc(); bus.fpu_doorbell_w = 0;
      bus.fpu_result_valid = 1; bus.fpu_result = 32'h3F00_0000; bus.fpu_flags = 5'b00100;
      bus.flags_clear = 1;
      cyc(); bus.fpu_result_valid = 0; bus.flags_clear = 0;
      chk("t6_clr_sticky", bus.flags_sticky, 5'b00100);
      chk("t6_clr_flast",  bus.flags_last, 5'b00100);
      chk("t6_clr_result", bus.result_out, 32'h3F00_0000);

      // Asynchronous reset in DONE, observed before any clock edge.
      #2 reset_n = 1'b0;
      #1 chk_all_zero("t7_async");
      @(negedge clk);
      reset_n = 1'b1;
      cyc();
      chk("t7_idle_busy", bus.busy, 0);
      chk("t7_state_dbg", bus.state_dbg, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fpu_result_register.md
Name: fpu_result_register

Overview:
- Return-path counterpart of the FPU operand/doorbell input register.
- Tracks one outstanding FPU/SIMD operation from doorbell to completion.
- Captures the FPU core's result and exception flags when the core signals completion, then holds them for host readback.
- Exposes busy/done/timeout status and a maskable interrupt; the host acknowledges completion to return the block to idle.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in BUSY without fpu_result_valid before the operation is declared timed out; legal range 2..2^CNT_W.
- CNT_W, 7: width of the timeout counter.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- fpu_rst_w  input  1  soft-reset request; effective only together with fpu_doorbell_w.
- fpu_doorbell_w  input  1  host doorbell, start of a scalar FPU operation.
- simd_doorbell  input  1  SIMD-path doorbell, start of an operation.
- fpu_result_valid  input  1  single-cycle pulse from the FPU core: result and flags valid.
- fpu_result  input  32  FPU core result.
- fpu_flags  input  5  exception flags {NV,DZ,OF,UF,NX}.
- host_read_ack  input  1  host has consumed the result; clears done.
- flags_clear  input  1  clears the sticky flags.
- irq_enable  input  1  interrupt mask, 1 = enabled.
- result_out  output  32  held result.
- flags_last  output  5  flags of the last captured result.
- flags_sticky  output  5  OR-accumulated flags since the last clear.
- busy  output  1  operation outstanding.
- done  output  1  result (or timeout) ready for the host.
- timeout_err  output  1  last operation ended by timeout.
- irq  output  1  registered interrupt, level.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs go to 0; state goes to IDLE; counter goes to 0.
- States: IDLE, BUSY, DONE. All outputs are registered; busy=1 exactly in BUSY, done=1 exactly in DONE.
- Define start = fpu_doorbell_w | simd_doorbell.
- Soft reset (fpu_rst_w & fpu_doorbell_w):
  - Highest priority; applies in any state.
  - Next cycle, every register equals its reset value and state is IDLE.
  - The coincident doorbell does not start an operation.
- IDLE:
  - start → BUSY next cycle, counter cleared to 0, timeout_err cleared.
  - fpu_result_valid is ignored.
  - host_read_ack is ignored.
- BUSY:
  - The counter increments each cycle.
  - fpu_result_valid at cycle N → at N+1:
    - result_out = fpu_result, flags_last = fpu_flags.
    - flags_sticky |= fpu_flags.
    - state = DONE, timeout_err = 0.
  - Counter == TIMEOUT_CYCLES-1 and no valid → next cycle:
    - state = DONE, timeout_err = 1.
    - result_out and the flag registers are unchanged.
  - Valid on the terminal count cycle → a normal capture; valid wins over timeout.
  - start while BUSY is ignored: no restart, no counter clear.
- DONE:
  - host_read_ack → IDLE next cycle; done and irq drop.
  - start → BUSY next cycle (counter cleared, timeout_err cleared); start wins over a simultaneous host_read_ack.
  - fpu_result_valid is ignored; a late result after a timeout is discarded.
- Outputs hold their values in all states except on the capture and clear events listed above.
- irq:
  - Set on the cycle DONE is entered if irq_enable=1.
  - While in DONE, irq follows irq_enable registered, i.e. irq = done & irq_enable one cycle later.
  - Cleared when DONE is exited or on soft reset.
- flags_clear:
  - Clears flags_sticky next cycle.
  - If it coincides with a capture, flags_sticky = fpu_flags (the clear happens before the OR).
- Latency:
  - Doorbell → busy: 1 cycle.
  - Valid → done/result_out: 1 cycle.
  - Ack → idle: 1 cycle.

Test Plan:
- Reset then doorbell; fpu_result_valid with result 0x3F800000, flags 5'b00001 two cycles later → busy=1 for 2 cycles; then done=1, result_out=0x3F800000, flags_last=flags_sticky=5'b00001, irq=1 (irq_enable=1).
- Second operation with flags 5'b10000, no flags_clear → flags_sticky=5'b10001; host_read_ack → done=0, irq=0, busy=0 next cycle.
- Timeout with TIMEOUT_CYCLES=64 and no valid → done=1 and timeout_err=1 exactly 64 cycles after busy rises; result_out unchanged; a valid pulse arriving afterwards does not change result_out.
- Valid on the terminal-count cycle → capture occurs, timeout_err=0; simultaneous host_read_ack + simd_doorbell in DONE → busy=1 next cycle, not idle.
- fpu_rst_w & fpu_doorbell_w mid-BUSY → all outputs 0, IDLE; a later valid is ignored. reset_n asserted mid-DONE → outputs 0 immediately, without waiting for a clock edge.
- irq_enable=0 on completion → done=1, irq=0; raising irq_enable while in DONE → irq=1 one cycle later; flags_clear coincident with capture of 5'b00100 → flags_sticky=5'b00100.
